if_fetch: RTL
=============

# if_fetch

Instruction fetch unit between the program counter and the decode stage. It takes the current PC, issues in-order read requests on a request/grant instruction bus, and buffers returned words in a 2-entry queue. Each cycle it presents one instruction plus its address to decode through a registered IF/ID output, and raises a hold request when it cannot accept the PC. On a jump it discards all in-flight and buffered fetches.

## Interface
Parameters:
- DEPTH, 2: max outstanding-plus-buffered fetches (credit limit); fixed at 2 for this revision.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- pc_i  in  32  current PC from the PC register
- jump_flag_i  in  1  redirect this cycle; flush everything
- hold_flag_i  in  3  pipeline hold code; IF/ID output frozen when ≥ `HOLD_IF
- fetch_hold_o  out  1  request to controller: hold PC this cycle (combinational)
- ibus_req_o  out  1  fetch request valid (combinational)
- ibus_addr_o  out  32  fetch address, equals pc_i
- ibus_gnt_i  in  1  request accepted this cycle
- ibus_rvalid_i  in  1  read data valid, in request order
- ibus_rdata_i  in  32  read data
- inst_o  out  32  instruction to decode (registered)
- inst_addr_o  out  32  address of inst_o (registered)
- inst_valid_o  out  1  inst_o is a real fetched instruction

## Operation
- Credits: `credits = outstanding + fifo_count`, where outstanding counts granted requests without data and fifo_count counts valid queue entries.
- ibus_req_o = !rst && !jump_flag_i && credits < DEPTH.
- Accept = ibus_req_o && ibus_gnt_i. On accept, outstanding+1 and pc_i is pushed into the address slot of the next free queue entry.
- fetch_hold_o = !jump_flag_i && !accept. The PC therefore advances only on accepted fetches or jumps.
- Response handling:
  - If discard > 0: drop the word and decrement discard.
  - Otherwise: write the data into the oldest pending entry, mark it valid, and decrement outstanding.
- Output update:
  - When hold_flag_i < `HOLD_IF and the queue has a valid head, load the head data and address, set inst_valid_o=1, and pop.
  - When hold_flag_i < `HOLD_IF and the queue is empty, load inst_o=`INST_NOP and set inst_valid_o=0. inst_addr_o keeps its value.
  - When hold_flag_i ≥ `HOLD_IF, all three outputs hold and nothing is popped.
- Jump (highest priority, overrides hold):
  - Next cycle: inst_o=`INST_NOP, inst_valid_o=0.
  - All queue entries are invalidated.
  - discard = outstanding minus any non-discarded response arriving in the same cycle; that response is also dropped.
  - outstanding = 0.
  - No request is issued in the jump cycle.
- Data bypass: a response arriving while the queue is empty and the output is not held goes into the queue. It reaches inst_o one cycle later; there is no bypass, so timing stays flop-to-flop.

## Timing
- Reset values: inst_o=32'h00000013, inst_addr_o=0, inst_valid_o=0, outstanding=0, discard=0, all queue entries invalid.
- ibus_req_o=0 and fetch_hold_o=1 while rst is high.
- Bus contract:
  - gnt is sampled in the same cycle as req.
  - rvalid arrives ≥1 cycle after grant, strictly in order.
  - There is never more than one rvalid per cycle.
- Minimum latency: grant at cycle N, rvalid at N+1, inst_o valid at N+3 (N+2: queue write, N+3: output register).
- Throughput: one instruction per cycle with 1-cycle memory, because a pop and an accept in the same cycle keep credits < 2.
- Simultaneous push and pop on the same cycle is legal. The counts change by net delta.
- Credits never exceed DEPTH, so the queue never overflows. Popping an empty queue is impossible by construction.
- Reset asserted mid-fetch: all state is cleared immediately. Responses still in flight after reset release are the bus's responsibility; the bus is also reset.

## Structure
- Shared constants added to defines.v:
  - `INST_NOP = 32'h00000013
  - `HOLD_NONE=3'd0, `HOLD_PC=3'd1, `HOLD_IF=3'd2, `HOLD_ID=3'd3
  - `FETCH_DEPTH=2
- One sub-module, fetch_queue: a 2-entry in-order queue with separate address-allocate and data-fill pointers, pop, flush, and valid/count outputs.
- if_fetch holds the counters, request/hold logic and the IF/ID output register.

## Test plan
- Reset, then 1-cycle memory with gnt=1, PC starting at 0x0:
  - inst_o carries 0x0, 0x4, 0x8 … on consecutive cycles from cycle 3.
  - inst_valid_o=1 continuously.
  - fetch_hold_o=0.
- gnt=0 for 3 cycles at PC 0x10:
  - fetch_hold_o=1 and ibus_addr_o stays 0x10 for those cycles.
  - No duplicate or skipped address reaches inst_addr_o.
- 4-cycle memory latency:
  - Credits saturate at 2 and ibus_req_o drops.
  - inst_valid_o=0 bubbles carry inst_o=0x00000013.
  - Order is preserved.
- jump_flag_i with jump address 0x100, while 2 requests are outstanding:
  - Both stale responses are discarded (discard goes 2→0).
  - The next valid inst_addr_o is 0x100.
  - The jump cycle produces no request.
- hold_flag_i=`HOLD_ID for 5 cycles with the queue full:
  - inst_o, inst_addr_o and inst_valid_o stay frozen.
  - ibus_req_o=0.
  - After release, the entries drain in order.
- Jump in the same cycle as rvalid and hold_flag_i=`HOLD_IF:
  - The response is dropped.
  - The output becomes NOP/invalid despite the hold.
  - Queue count is 0 next cycle.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage constants: NOP encoding, pipeline hold codes and
// fetch credit depth.
package if_fetch_pkg;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  localparam logic [2:0] HOLD_NONE = 3'd0;
  localparam logic [2:0] HOLD_PC   = 3'd1;
  localparam logic [2:0] HOLD_IF   = 3'd2;
  localparam logic [2:0] HOLD_ID   = 3'd3;

  localparam int FETCH_DEPTH = 2;

endpackage

// File: rtl/if_fetch_if.sv
// Request/grant instruction bus between the fetch unit (master) and memory.
// req/addr/gnt handshake per request; rvalid/rdata return in request order.
interface if_fetch_if;

  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/if_fetch_queue.sv
// 2-entry in-order fetch queue: push allocates an address slot, fill writes
// data to the oldest pending slot, pop retires the head. Ports: push_i/
// push_addr_i, fill_i/fill_data_i, pop_i, flush_i, head_*_o, count_o.
module if_fetch_queue
  import if_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic [31:0] push_addr_i,
  input  logic        fill_i,
  input  logic [31:0] fill_data_i,
  input  logic        pop_i,
  input  logic        flush_i,
  output logic [31:0] head_addr_o,
  output logic [31:0] head_data_o,
  output logic        head_valid_o,
  output logic [1:0]  count_o
);

  logic [31:0] addr_q [2];
  logic [31:0] data_q [2];
  logic [1:0]  vld_q;
  logic        wr_ptr_q;
  logic        fill_ptr_q;
  logic        rd_ptr_q;

  // Push may target the slot being popped in the same cycle; that slot only
  // regains valid when its data is filled later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      vld_q      <= '0;
      wr_ptr_q   <= 1'b0;
      fill_ptr_q <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else if (flush_i) begin
      vld_q      <= '0;
      wr_ptr_q   <= 1'b0;
      fill_ptr_q <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      if (push_i) begin
        addr_q[wr_ptr_q] <= push_addr_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (fill_i) begin
        data_q[fill_ptr_q] <= fill_data_i;
        vld_q[fill_ptr_q]  <= 1'b1;
        fill_ptr_q         <= ~fill_ptr_q;
      end
      if (pop_i) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= ~rd_ptr_q;
      end
    end
  end

  assign head_addr_o  = addr_q[rd_ptr_q];
  assign head_data_o  = data_q[rd_ptr_q];
  assign head_valid_o = vld_q[rd_ptr_q];
  assign count_o      = {1'b0, vld_q[0]} + {1'b0, vld_q[1]};

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch unit: issues in-order bus reads at pc_i, buffers words
// and drives the registered IF/ID bundle (inst_o/inst_addr_o/inst_valid_o).
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        jump_flag_i,
  input  logic [2:0]  hold_flag_i,
  output logic        fetch_hold_o,
  if_fetch_if.master  ibus,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  logic [1:0]  outst_q, outst_d;
  logic [3:0]  disc_q, disc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] addr_q, addr_d;
  logic        vld_q, vld_d;

  logic [31:0] head_addr;
  logic [31:0] head_data;
  logic        head_vld;
  logic [1:0]  q_cnt;
  logic [2:0]  credits;
  logic        out_en, pop, accept;
  logic        keep, drop, fill;

  assign out_en = hold_flag_i < HOLD_IF;
  assign pop    = !jump_flag_i && out_en && head_vld;

  // The entry popped this cycle is already free, so a 1-cycle bus can
  // stream one fetch per cycle without tripping the credit limit.
  assign credits = 3'(outst_q) + 3'(q_cnt) - 3'(pop);

  assign ibus.req  = !rst && !jump_flag_i && (credits < 3'(DEPTH));
  assign ibus.addr = pc_i;
  assign accept    = ibus.req && ibus.gnt;

  assign fetch_hold_o = !jump_flag_i && !accept;

  assign drop = ibus.rvalid && (disc_q != '0);
  assign keep = ibus.rvalid && (disc_q == '0);
  assign fill = keep && !jump_flag_i;

  always_comb begin
    outst_d = outst_q + 2'(accept) - 2'(keep);
    disc_d  = disc_q - 4'(drop);
    if (jump_flag_i) begin
      outst_d = '0;
      disc_d  = disc_d + 4'(outst_q) - 4'(keep);
    end
  end

  always_comb begin
    inst_d = inst_q;
    addr_d = addr_q;
    vld_d  = vld_q;
    if (jump_flag_i) begin
      inst_d = INST_NOP;
      vld_d  = 1'b0;
    end else if (out_en) begin
      if (head_vld) begin
        inst_d = head_data;
        addr_d = head_addr;
        vld_d  = 1'b1;
      end else begin
        inst_d = INST_NOP;
        vld_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outst_q <= '0;
      disc_q  <= '0;
      inst_q  <= INST_NOP;
      addr_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      outst_q <= outst_d;
      disc_q  <= disc_d;
      inst_q  <= inst_d;
      addr_q  <= addr_d;
      vld_q   <= vld_d;
    end
  end

  if_fetch_queue u_queue (
    .clk          (clk),
    .rst          (rst),
    .push_i       (accept),
    .push_addr_i  (pc_i),
    .fill_i       (fill),
    .fill_data_i  (ibus.rdata),
    .pop_i        (pop),
    .flush_i      (jump_flag_i),
    .head_addr_o  (head_addr),
    .head_data_o  (head_data),
    .head_valid_o (head_vld),
    .count_o      (q_cnt)
  );

  assign inst_o       = inst_q;
  assign inst_addr_o  = addr_q;
  assign inst_valid_o = vld_q;

endmodule
